// File: rtl/b2b_event_router.sv
// b2b_event_router: pulls complete events from NUM_CLUSTERS FWFT cluster FIFOs,
// arbitrates round-robin per event, and multicasts each event to the output
// boards selected by the destination mask in the header word.
//
// Ports:
//   b2b_clk, b2b_rst_n        clock, asynchronous active-low reset
//   cluster_data/empty        FWFT head words and empty flags per cluster
//   cluster_req               pop strobe, one-hot or zero (combinational)
//   output_board_event/wren   registered write data / enables per board
//   output_board_almost_full  per-board back-pressure
//   board_id                  constant BOARD_ID
//   stat_events/drops/errors  saturating counters
//
// Optional: define B2B_ROUTER_STATS_EN to build the statistics counters;
// otherwise the stat_* ports are tied to zero.
module b2b_event_router #(
  parameter int unsigned DATA_WIDTH      = 65,
  parameter int unsigned NUM_CLUSTERS    = 4,
  parameter int unsigned NUM_OUTPUTS     = 14,
  parameter int unsigned MASK_LSB        = 0,
  parameter int unsigned MAX_EVENT_WORDS = 1024,
  parameter int unsigned BOARD_ID        = 0
) (
  input  logic                              b2b_clk,
  input  logic                              b2b_rst_n,
  input  logic [NUM_CLUSTERS*DATA_WIDTH-1:0] cluster_data,
  input  logic [NUM_CLUSTERS-1:0]           cluster_empty,
  output logic [NUM_CLUSTERS-1:0]           cluster_req,
  output logic [NUM_OUTPUTS*DATA_WIDTH-1:0] output_board_event,
  output logic [NUM_OUTPUTS-1:0]            output_board_wren,
  input  logic [NUM_OUTPUTS-1:0]            output_board_almost_full,
  output logic [7:0]                        board_id,
  output logic [31:0]                       stat_events,
  output logic [31:0]                       stat_drops,
  output logic [31:0]                       stat_errors
);

  localparam int unsigned CW  = (NUM_CLUSTERS > 1) ? $clog2(NUM_CLUSTERS) : 1;
  localparam int unsigned WCW = $clog2(MAX_EVENT_WORDS + 1);

  typedef enum logic [1:0] {IDLE, STREAM, DROP} state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           ptr_q, ptr_d, cur_q, cur_d;
  logic [NUM_OUTPUTS-1:0]  mask_q, mask_d;
  logic [WCW-1:0]          cnt_q, cnt_d;
  logic                    wr_d;
  logic                    inc_events, inc_drops, inc_errors;

  logic [DATA_WIDTH-1:0]   words [NUM_CLUSTERS];
  logic                    grant_vld;
  logic [CW-1:0]           grant_idx, rr_idx, sel, ptr_adv;
  logic [DATA_WIDTH-1:0]   head_c;
  logic                    head_flag;
  logic [NUM_OUTPUTS-1:0]  head_mask;
  logic                    stall;

  assign board_id = 8'(BOARD_ID);

  for (genvar g = 0; g < NUM_CLUSTERS; g++) begin : g_words
    assign words[g] = cluster_data[g*DATA_WIDTH +: DATA_WIDTH];
  end

  // First non-empty cluster at or after ptr, wrapping around
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    rr_idx    = '0;
    for (int unsigned i = 0; i < NUM_CLUSTERS; i++) begin
      rr_idx = CW'((32'(ptr_q) + i) % NUM_CLUSTERS);
      if (!grant_vld && !cluster_empty[rr_idx]) begin
        grant_vld = 1'b1;
        grant_idx = rr_idx;
      end
    end
  end

  // Head word of the granted cluster in IDLE, of the owning cluster otherwise
  assign sel       = (state_q == IDLE) ? grant_idx : cur_q;
  assign head_c    = words[sel];
  assign head_flag = head_c[DATA_WIDTH-1];
  assign head_mask = head_c[MASK_LSB +: NUM_OUTPUTS];
  assign stall     = |(output_board_almost_full & mask_q);
  assign ptr_adv   = (cur_q == CW'(NUM_CLUSTERS - 1)) ? '0 : cur_q + CW'(1);

  // State register
  always_ff @(posedge b2b_clk or negedge b2b_rst_n) begin
    if (!b2b_rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cur_q   <= '0;
      mask_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cur_q   <= cur_d;
      mask_q  <= mask_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state, pop strobes and counter events
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cur_d       = cur_q;
    mask_d      = mask_q;
    cnt_d       = cnt_q;
    cluster_req = '0;
    wr_d        = 1'b0;
    inc_events  = 1'b0;
    inc_drops   = 1'b0;
    inc_errors  = 1'b0;
    unique case (state_q)
      IDLE: begin
        // reset gate keeps the orphan pop from firing while held in reset
        if (grant_vld && b2b_rst_n) begin
          if (!head_flag) begin
            cluster_req[grant_idx] = 1'b1;
            inc_errors             = 1'b1;
          end else begin
            cur_d = grant_idx;
            cnt_d = '0;
            if (head_mask != '0) begin
              mask_d  = head_mask;
              state_d = STREAM;
            end else begin
              state_d = DROP;
            end
          end
        end
      end
      STREAM, DROP: begin
        if (!cluster_empty[cur_q] && (state_q == DROP || !stall)) begin
          cluster_req[cur_q] = 1'b1;
          wr_d               = (state_q == STREAM);
          cnt_d              = cnt_q + WCW'(1);
          // the header is word 1, so a flagged word after it is the footer
          if (head_flag && cnt_q != '0) begin
            state_d = IDLE;
            ptr_d   = ptr_adv;
            if (state_q == STREAM) inc_events = 1'b1;
            else                   inc_drops  = 1'b1;
          end else if (cnt_q == WCW'(MAX_EVENT_WORDS - 1)) begin
            state_d    = IDLE;
            ptr_d      = ptr_adv;
            inc_errors = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output write port; data on each board holds until its next write
  always_ff @(posedge b2b_clk or negedge b2b_rst_n) begin
    if (!b2b_rst_n) begin
      output_board_wren  <= '0;
      output_board_event <= '0;
    end else begin
      output_board_wren <= wr_d ? mask_q : '0;
      for (int j = 0; j < NUM_OUTPUTS; j++) begin
        if (wr_d && mask_q[j]) output_board_event[j*DATA_WIDTH +: DATA_WIDTH] <= head_c;
      end
    end
  end

`ifdef B2B_ROUTER_STATS_EN
  // Saturating statistics
  always_ff @(posedge b2b_clk or negedge b2b_rst_n) begin
    if (!b2b_rst_n) begin
      stat_events <= '0;
      stat_drops  <= '0;
      stat_errors <= '0;
    end else begin
      if (inc_events && stat_events != '1) stat_events <= stat_events + 32'd1;
      if (inc_drops  && stat_drops  != '1) stat_drops  <= stat_drops  + 32'd1;
      if (inc_errors && stat_errors != '1) stat_errors <= stat_errors + 32'd1;
    end
  end
`else
  logic unused_stats;
  assign unused_stats = ^{inc_events, inc_drops, inc_errors};
  assign stat_events  = '0;
  assign stat_drops   = '0;
  assign stat_errors  = '0;
`endif

endmodule

// File: tb/tb_b2b_event_router.sv
`timescale 1ns/1ps
module tb_b2b_event_router;
  localparam int DW = 65, NC = 4, NO = 14, MAXW = 8;
`ifdef B2B_ROUTER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic              b2b_clk = 1'b0;
  logic              b2b_rst_n = 1'b0;
  logic [NC*DW-1:0]  cluster_data = '0;
  logic [NC-1:0]     cluster_empty = '1;
  logic [NC-1:0]     cluster_req;
  logic [NO*DW-1:0]  output_board_event;
  logic [NO-1:0]     output_board_wren;
  logic [NO-1:0]     output_board_almost_full = '0;
  logic [7:0]        board_id;
  logic [31:0]       stat_events, stat_drops, stat_errors;

  always #5 b2b_clk = ~b2b_clk;

  b2b_event_router #(
    .DATA_WIDTH(DW), .NUM_CLUSTERS(NC), .NUM_OUTPUTS(NO), .MASK_LSB(0),
    .MAX_EVENT_WORDS(MAXW), .BOARD_ID(8'h5A)
  ) dut (
    .b2b_clk(b2b_clk), .b2b_rst_n(b2b_rst_n),
    .cluster_data(cluster_data), .cluster_empty(cluster_empty), .cluster_req(cluster_req),
    .output_board_event(output_board_event), .output_board_wren(output_board_wren),
    .output_board_almost_full(output_board_almost_full), .board_id(board_id),
    .stat_events(stat_events), .stat_drops(stat_drops), .stat_errors(stat_errors)
  );

  logic [DW-1:0] fifo [NC][$];
  logic [DW-1:0] got  [NO][$];
  int            wcyc [NO][$];
  int            pop_cyc [$];
  int            cyc = 0, multi_req = 0, stall_viol = 0, af_cycles = 0;
  int            total = 0, bad = 0;
  logic [NC-1:0] req_s = '0;

  function automatic logic [DW-1:0] wd(input logic flag, input logic [63:0] v);
    return {flag, v};
  endfunction

  // FWFT FIFO model: pops granted words, then presents the new heads
  initial begin
    forever begin
      @(posedge b2b_clk);
      cyc++;
      #1;
      for (int k = 0; k < NC; k++)
        if (req_s[k] && fifo[k].size() > 0) void'(fifo[k].pop_front());
      req_s = '0;
      for (int k = 0; k < NC; k++) begin
        cluster_empty[k] = (fifo[k].size() == 0);
        cluster_data[k*DW +: DW] = (fifo[k].size() > 0) ? fifo[k][0] : '0;
      end
    end
  end

  // Monitor: pops, writes and back-pressure behaviour
  always @(negedge b2b_clk) begin
    req_s = cluster_req;
    if ($countones(cluster_req) > 1) multi_req++;
    if (cluster_req != '0) pop_cyc.push_back(cyc);
    for (int j = 0; j < NO; j++)
      if (output_board_wren[j]) begin
        got[j].push_back(output_board_event[j*DW +: DW]);
        wcyc[j].push_back(cyc);
      end
    if (output_board_almost_full[1]) begin
      af_cycles++;
      if (cluster_req != '0) stall_viol++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1);
  end

  task automatic clear_log();
    for (int j = 0; j < NO; j++) begin got[j].delete(); wcyc[j].delete(); end
    pop_cyc.delete();
    stall_viol = 0;
    af_cycles  = 0;
  endtask

  task automatic do_reset();
    @(negedge b2b_clk);
    b2b_rst_n = 1'b0;
    output_board_almost_full = '0;
    for (int k = 0; k < NC; k++) fifo[k].delete();
    repeat (3) @(negedge b2b_clk);
    b2b_rst_n = 1'b1;
    clear_log();
  endtask

  task automatic drain(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge b2b_clk); #1;
      if (fifo[0].size() == 0 && fifo[1].size() == 0 && fifo[2].size() == 0 &&
          fifo[3].size() == 0 && cluster_empty == '1) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (4) begin @(negedge b2b_clk); #1; end
  endtask

  task automatic test_reset();
    @(negedge b2b_clk);
    b2b_rst_n = 1'b0;
    @(negedge b2b_clk); #1;
    total++;
    if (output_board_wren !== '0 || output_board_event !== '0 || cluster_req !== '0) begin
      bad++;
      $display("FAIL reset_outputs wren=%h req=%h event_nonzero=%0d", output_board_wren,
               cluster_req, output_board_event != '0);
    end
    total++;
    if (stat_events !== 0 || stat_drops !== 0 || stat_errors !== 0) begin
      bad++;
      $display("FAIL reset_stats got %0d/%0d/%0d want 0/0/0", stat_events, stat_drops, stat_errors);
    end
    total++;
    if (board_id !== 8'h5A) begin
      bad++;
      $display("FAIL board_id got %h want 5a", board_id);
    end
    do_reset();
  endtask

  task automatic test_single_multicast();
    logic [DW-1:0] exp [$];
    bit ok, err;
    do_reset();
    exp = '{wd(1, 64'h5), wd(0, 64'hD0), wd(0, 64'hD1), wd(1, 64'hF00D)};
    @(negedge b2b_clk);
    foreach (exp[i]) fifo[1].push_back(exp[i]);
    drain(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL t1_drain timeout remaining=%0d want 0", fifo[1].size()); end
    for (int b = 0; b <= 2; b += 2) begin
      err = (got[b].size() != 4);
      if (!err) foreach (exp[i]) if (got[b][i] !== exp[i]) err = 1'b1;
      total++;
      if (err) begin bad++; $display("FAIL t1_board%0d_data got %0d words want 4 matching", b, got[b].size()); end
    end
    err = 1'b0;
    for (int j = 0; j < NO; j++) if (j != 0 && j != 2 && got[j].size() != 0) err = 1'b1;
    total++;
    if (err) begin bad++; $display("FAIL t1_unselected got writes on unselected boards want none"); end
    err = (pop_cyc.size() != 4 || wcyc[0].size() != 4);
    if (!err) for (int i = 0; i < 4; i++)
      if (wcyc[0][i] != pop_cyc[i] + 1 || wcyc[0][i] != wcyc[0][0] + i) err = 1'b1;
    total++;
    if (err) begin bad++; $display("FAIL t1_latency pops=%0d writes=%0d want 4 consecutive, 1 cycle later", pop_cyc.size(), wcyc[0].size()); end
    total++;
    if (output_board_wren !== '0 || output_board_event[0 +: DW] !== exp[3]) begin
      bad++;
      $display("FAIL t1_hold wren=%h data=%h want 0 and %h", output_board_wren, output_board_event[0 +: DW], exp[3]);
    end
    total++;
    if (stat_events !== (STATS ? 32'd1 : 32'd0)) begin
      bad++;
      $display("FAIL t1_stat_events got %0d want %0d", stat_events, STATS ? 1 : 0);
    end
  endtask

  task automatic test_round_robin();
    logic [DW-1:0] exp [$];
    bit ok, err;
    do_reset();
    @(negedge b2b_clk);
    for (int k = 0; k < NC; k++) begin
      logic [63:0] tag;
      tag = 64'(k) << 32;
      fifo[k].push_back(wd(1, tag | 64'h1));
      fifo[k].push_back(wd(0, tag | 64'h100));
      fifo[k].push_back(wd(1, tag | 64'h200));
      exp.push_back(wd(1, tag | 64'h1));
      exp.push_back(wd(0, tag | 64'h100));
      exp.push_back(wd(1, tag | 64'h200));
    end
    drain(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL t2_drain timeout want all clusters empty"); end
    err = (got[0].size() != 12);
    if (!err) foreach (exp[i]) if (got[0][i] !== exp[i]) err = 1'b1;
    total++;
    if (err) begin bad++; $display("FAIL t2_order got %0d words want 12 in cluster order 0,1,2,3", got[0].size()); end
    total++;
    if (multi_req != 0) begin bad++; $display("FAIL t2_onehot got %0d multi-bit req cycles want 0", multi_req); end
    // pointer back at 0: cluster 0 must win over cluster 3
    clear_log();
    @(negedge b2b_clk);
    fifo[3].push_back(wd(1, 64'h3_0000_0001));
    fifo[3].push_back(wd(1, 64'h3_0000_0F00));
    fifo[0].push_back(wd(1, 64'h0_0000_0001));
    fifo[0].push_back(wd(1, 64'h0_0000_0F00));
    drain(ok);
    total++;
    if (got[0].size() != 4 || got[0][0] !== wd(1, 64'h0_0000_0001) || got[0][2] !== wd(1, 64'h3_0000_0001)) begin
      bad++;
      $display("FAIL t2_ptr_wrap got %0d words first=%h want cluster 0 event first", got[0].size(),
               got[0].size() > 0 ? got[0][0] : '0);
    end
  endtask

  task automatic test_back_pressure();
    logic [DW-1:0] exp [$];
    bit ok, err;
    int gap;
    do_reset();
    exp = '{wd(1, 64'h3), wd(0, 64'h10), wd(0, 64'h11), wd(0, 64'h12), wd(0, 64'h13), wd(1, 64'hFF)};
    @(negedge b2b_clk);
    foreach (exp[i]) fifo[0].push_back(exp[i]);
    for (int i = 0; i < 50 && got[0].size() < 2; i++) begin @(negedge b2b_clk); #1; end
    @(posedge b2b_clk); #1;
    output_board_almost_full[1] = 1'b1;
    repeat (5) @(posedge b2b_clk);
    #1;
    output_board_almost_full[1] = 1'b0;
    drain(ok);
    total++;
    if (af_cycles != 5 || stall_viol != 0) begin
      bad++;
      $display("FAIL t3_stall af_cycles=%0d req_during_af=%0d want 5 and 0", af_cycles, stall_viol);
    end
    err = (got[0].size() != 6 || got[1].size() != 6);
    if (!err) foreach (exp[i]) if (got[0][i] !== exp[i] || got[1][i] !== exp[i]) err = 1'b1;
    total++;
    if (err) begin bad++; $display("FAIL t3_data got %0d/%0d words want 6/6 matching", got[0].size(), got[1].size()); end
    gap = 0;
    err = (wcyc[0].size() != wcyc[1].size());
    if (!err) for (int i = 0; i < wcyc[0].size(); i++) begin
      if (wcyc[0][i] != wcyc[1][i]) err = 1'b1;
      if (i > 0 && wcyc[0][i] - wcyc[0][i-1] > gap) gap = wcyc[0][i] - wcyc[0][i-1];
    end
    total++;
    if (err || gap != 6) begin bad++; $display("FAIL t3_gap matched=%0d max_gap=%0d want 1 and 6", !err, gap); end
  endtask

  task automatic test_drop();
    bit ok, err;
    do_reset();
    @(negedge b2b_clk);
    fifo[0].push_back(wd(1, 64'hABC0000));
    for (int i = 0; i < 3; i++) fifo[0].push_back(wd(0, 64'(i)));
    fifo[0].push_back(wd(1, 64'hFFFF));
    drain(ok);
    err = 1'b0;
    for (int j = 0; j < NO; j++) if (got[j].size() != 0) err = 1'b1;
    total++;
    if (!ok || err) begin bad++; $display("FAIL t4_drop drained=%0d writes_seen=%0d want 1 and 0", ok, err); end
    total++;
    if (stat_drops !== (STATS ? 32'd1 : 32'd0) || stat_events !== 0) begin
      bad++;
      $display("FAIL t4_stat_drops got %0d events=%0d want %0d and 0", stat_drops, stat_events, STATS ? 1 : 0);
    end
  endtask

  task automatic test_orphan();
    int push_cyc;
    bit ok, err;
    do_reset();
    @(negedge b2b_clk);
    push_cyc = cyc;
    fifo[2].push_back(wd(0, 64'hBAD));
    fifo[2].push_back(wd(1, 64'h4));
    fifo[2].push_back(wd(0, 64'h77));
    fifo[2].push_back(wd(1, 64'h99));
    drain(ok);
    total++;
    if (pop_cyc.size() == 0 || pop_cyc[0] != push_cyc + 1) begin
      bad++;
      $display("FAIL t5_orphan_pop got first pop cycle %0d want %0d", pop_cyc.size() ? pop_cyc[0] : -1, push_cyc + 1);
    end
    err = (got[2].size() != 3);
    if (!err) err = (got[2][0] !== wd(1, 64'h4) || got[2][1] !== wd(0, 64'h77) || got[2][2] !== wd(1, 64'h99));
    total++;
    if (!ok || err) begin bad++; $display("FAIL t5_next_event got %0d words on board 2 want 3 matching", got[2].size()); end
    total++;
    if (stat_errors !== (STATS ? 32'd1 : 32'd0) || stat_events !== (STATS ? 32'd1 : 32'd0)) begin
      bad++;
      $display("FAIL t5_stats errors=%0d events=%0d want %0d and %0d", stat_errors, stat_events, STATS ? 1 : 0, STATS ? 1 : 0);
    end
  endtask

  task automatic test_watchdog();
    logic [DW-1:0] exp [$];
    bit ok, err;
    do_reset();
    exp.push_back(wd(1, 64'h1));
    for (int i = 1; i <= 11; i++) exp.push_back(wd(0, 64'(100 + i)));
    @(negedge b2b_clk);
    foreach (exp[i]) fifo[0].push_back(exp[i]);
    for (int i = 0; i < 100 && got[0].size() < 8; i++) begin @(negedge b2b_clk); #1; end
    total++;
    if (stat_errors !== (STATS ? 32'd1 : 32'd0)) begin
      bad++;
      $display("FAIL t6_abort_count got %0d want %0d", stat_errors, STATS ? 1 : 0);
    end
    drain(ok);
    err = (got[0].size() != 8);
    if (!err) for (int i = 0; i < 8; i++) if (got[0][i] !== exp[i]) err = 1'b1;
    total++;
    if (!ok || err) begin bad++; $display("FAIL t6_forwarded got %0d words drained=%0d want 8 and 1", got[0].size(), ok); end
    total++;
    if (stat_errors !== (STATS ? 32'd5 : 32'd0) || stat_events !== 0 || stat_drops !== 0) begin
      bad++;
      $display("FAIL t6_orphans errors=%0d events=%0d drops=%0d want %0d,0,0", stat_errors, stat_events, stat_drops, STATS ? 5 : 0);
    end
  endtask

  initial begin
    test_reset();
    test_single_multicast();
    test_round_robin();
    test_back_pressure();
    test_drop();
    test_orphan();
    test_watchdog();
    total++;
    if (multi_req != 0) begin bad++; $display("FAIL onehot_all got %0d multi-bit req cycles want 0", multi_req); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/b2b_event_router.md
Name: b2b_event_router

Overview:
Parametrised successor to the board-to-board switch. Pulls complete events from NUM_CLUSTERS first-word-fall-through (FWFT) cluster FIFOs and arbitrates round-robin at event granularity. Each event is multicast to any subset of NUM_OUTPUTS output-board FIFOs, selected by a destination mask in the event header. The block sits between the cluster-collection FIFOs and the per-board transmit FIFOs.

Parameters:
DATA_WIDTH, 65, word width; bit DATA_WIDTH-1 is the metadata flag.
NUM_CLUSTERS, 4, number of input cluster FIFOs (1..16).
NUM_OUTPUTS, 14, number of output boards (1..DATA_WIDTH-1-MASK_LSB).
MASK_LSB, 0, LSB of the destination mask in the header word.
MAX_EVENT_WORDS, 1024, watchdog limit on words per event, header and footer included.
BOARD_ID, 0, this board's id; reported on board_id only.

Ports:
b2b_clk  in  1  sole clock
b2b_rst_n  in  1  asynchronous active-low reset
cluster_data  in  NUM_CLUSTERS*DATA_WIDTH  FWFT head words; cluster k at [k*DATA_WIDTH +: DATA_WIDTH]
cluster_empty  in  NUM_CLUSTERS  FIFO empty, one bit per cluster
cluster_req  out  NUM_CLUSTERS  read-enable (pop), one-hot or zero
output_board_event  out  NUM_OUTPUTS*DATA_WIDTH  write data; board j at [j*DATA_WIDTH +: DATA_WIDTH]
output_board_wren  out  NUM_OUTPUTS  write-enable per board
output_board_almost_full  in  NUM_OUTPUTS  back-pressure per board
board_id  out  8  constant BOARD_ID
stat_events  out  32  events forwarded (see Optional Feature)
stat_drops  out  32  events with empty mask
stat_errors  out  32  orphan words plus watchdog aborts

Behaviour:
- Reset: all outputs 0 except board_id. State IDLE, round-robin pointer 0, counters 0, mask 0.
- Event framing:
  - Header: the first word, with flag=1.
  - Body: words with flag=0.
  - Footer: the next word with flag=1; it ends the event.
  - A header-and-footer-only event (2 words) is legal.
- Destination mask: header bits [MASK_LSB +: NUM_OUTPUTS].
- State IDLE:
  - Eligible clusters are those with !cluster_empty.
  - Grant goes to the first eligible cluster at or after pointer ptr, searching upward with wrap-around.
  - If no cluster is eligible: stay in IDLE, drive req=0.
  - Granted head has flag=0 (orphan word): pop it the same cycle, no write, stat_errors+1, stay in IDLE, ptr unchanged.
  - Granted head has flag=1 and mask!=0: latch mask and cluster index, go to STREAM. No pop this cycle.
  - Granted head has flag=1 and mask==0: latch cluster index, go to DROP.
- State STREAM:
  - cluster_req[c] = !cluster_empty[c] && !(|(output_board_almost_full & mask)).
  - Each popped word is registered onto every selected output the next cycle with wren=1. Write latency is 1 cycle; unselected boards get wren=0.
  - Word counter increments per pop; it counts the header as word 1.
  - Footer popped: go to IDLE, ptr = c+1 mod NUM_CLUSTERS, stat_events+1.
- State DROP:
  - Pop whenever !cluster_empty[c], with no writes and no back-pressure check.
  - On footer: go to IDLE, ptr advance, stat_drops+1.
- Watchdog: in STREAM or DROP, if the pop of word MAX_EVENT_WORDS is not a footer:
  - finish that write normally;
  - go to IDLE, stat_errors+1, ptr advance.
  - The remaining words of that event are later discarded as orphans.
- Back-pressure:
  - almost_full on any selected board stalls the whole event; no partial-mask forwarding.
  - The downstream almost_full threshold must absorb 1 in-flight word.
- Body and footer contents are never re-checked for mask.
- Cluster empty mid-event: stall in STREAM with no timeout; the watchdog counts only popped words.
- At most one cluster_req bit is high per cycle.
- output_board_event data is held after wren drops.
- Counters saturate at 0xFFFFFFFF.
- Asynchronous reset mid-event abandons the event. Outputs clear immediately; the first post-reset pop of leftover words counts as an orphan.

Optional Feature:
- Macro B2B_ROUTER_STATS_EN.
- Defined: stat_events, stat_drops and stat_errors count as described above.
- Undefined: the counter logic is removed and the three ports are tied to 0. Routing behaviour is identical.

Test Plan:
1. Cluster 1 queues the event H(mask=0x0005), D0, D1, F (4 words) with all boards ready -> boards 0 and 2 each receive the 4 words on 4 consecutive cycles, 1 cycle after each pop; other boards wren=0; stat_events=1.
2. All 4 clusters hold a 3-word event with ptr=0 -> grants in order 0,1,2,3; no word interleaving between events; ptr returns to 0.
3. Mask=0x0003 and almost_full[1] asserted for 5 cycles mid-event -> cluster_req low for those 5 cycles; boards 0 and 1 receive identical, gap-matched word streams.
4. Header with mask=0 followed by 3 words and a footer -> all words popped, no wren, stat_drops=1.
5. Cluster 2 head word with flag=0 in IDLE -> popped in 1 cycle, stat_errors=1, next valid event routes normally.
6. MAX_EVENT_WORDS=8, event of 12 words without a footer -> 8 words forwarded, stat_errors=1; the remaining 4 words are discarded as orphans, bringing stat_errors to 5. With the macro undefined, all stat ports stay 0.
